// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and defaults for the prefetching fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int unsigned c_ADDR_W   = 16;
    localparam int unsigned c_INSTR_W  = 16;
    localparam int unsigned c_RESET_PC = 0;
    localparam int unsigned c_PC_INC   = 2;

    // FETCH: idle, WAIT: response kept, KILL: response discarded
    typedef logic [1:0] state_t;
    localparam state_t c_FETCH = 2'd0;
    localparam state_t c_WAIT  = 2'd1;
    localparam state_t c_KILL  = 2'd2;

    typedef struct packed {
        logic [c_ADDR_W-1:0]  pc;
        logic [c_INSTR_W-1:0] instr;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_prefetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit_if
// Description : Redirect, instruction-memory and decode-side handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_prefetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req, imem_addr,
        input  imem_gnt, imem_rsp_valid, imem_rsp_data,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req, imem_addr,
        output imem_gnt, imem_rsp_valid, imem_rsp_data,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular FIFO of fetched entries; flush overrides push/pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   push,
    input  wire logic                   pop,
    input  wire logic                   flush,
    input  wire logic [WIDTH-1:0]       push_data,
    output logic      [WIDTH-1:0]       head,
    output logic      [$clog2(DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(DEPTH));
    assign w_pop  = pop  && !flush && !empty;
    assign w_push = push && !flush && (!full || w_pop);
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: entries beyond count are never observed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_unit
// Description : Fetch PC owner with one-outstanding imem request and prefetch queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = c_ADDR_W,
    parameter int INSTR_W  = c_INSTR_W,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = c_RESET_PC,
    parameter int PC_INC   = c_PC_INC
) (
    input wire logic             clk,
    input wire logic             rst,
    fetch_prefetch_unit_if.master bus
);
    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] c_RST_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_INC    = ADDR_W'(PC_INC);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } q_entry_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;

    logic              w_rsp_accept;
    logic              w_pop;
    logic              w_free;
    logic              w_req;
    logic              w_grant;
    logic [CNT_W:0]    w_next_cnt;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    q_entry_t          w_push_entry;
    q_entry_t          w_head;

    assign w_rsp_accept = (r_state == c_WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    assign w_pop        = !w_empty && bus.out_ready && !bus.redirect_valid;

    // Occupancy after this cycle's push/pop must leave room for the new request.
    assign w_next_cnt = {1'b0, w_count} + {{CNT_W{1'b0}}, w_rsp_accept}
                      - {{CNT_W{1'b0}}, w_pop};
    // A full queue implies nothing is outstanding, so only a pop frees a slot.
    assign w_free = w_full ? w_pop : (w_next_cnt < (CNT_W+1)'(DEPTH));

    assign w_req = !rst && !bus.redirect_valid && w_free &&
                   ((r_state == c_FETCH) || ((r_state == c_WAIT) && bus.imem_rsp_valid));
    assign w_grant = w_req && bus.imem_gnt;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_fetch_pc;

    assign w_push_entry.pc    = r_req_pc;
    assign w_push_entry.instr = bus.imem_rsp_data;

    assign bus.out_valid = !w_empty;
    assign bus.out_instr = w_head.instr;
    assign bus.out_pc    = w_head.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_FETCH;
            r_fetch_pc <= c_RST_PC;
            r_req_pc   <= c_RST_PC;
        end else if (bus.redirect_valid) begin
            r_fetch_pc <= bus.redirect_pc;
            if (r_state != c_FETCH && !bus.imem_rsp_valid)
                r_state <= c_KILL;
            else
                r_state <= c_FETCH;
        end else if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + c_INC;
            r_req_pc   <= r_fetch_pc;
            r_state    <= c_WAIT;
        end else begin
            case (r_state)
                c_WAIT,
                c_KILL:  if (bus.imem_rsp_valid) r_state <= c_FETCH;
                c_FETCH: r_state <= c_FETCH;
                default: r_state <= c_FETCH;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INSTR_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (w_rsp_accept),
        .pop       (w_pop),
        .flush     (bus.redirect_valid),
        .push_data (w_push_entry),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Owns the architectural fetch PC and issues requests to a variable-latency instruction memory through a req/gnt/rsp handshake.
- Buffers returned instructions and their PCs in a DEPTH-entry prefetch queue that decode drains with a valid/ready handshake.
- Handles redirects (branch/jump/exception), including squashing a response that is still in flight.

Parameters:
- ADDR_W, 16: PC and memory address width.
- INSTR_W, 16: instruction width.
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 0: fetch PC loaded on reset.
- PC_INC, 2: sequential PC increment in bytes.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  load redirect_pc and flush; has priority over everything else.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address, equal to the fetch PC.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rsp_valid  in  1  response data valid; arrives at least 1 cycle after the grant.
- imem_rsp_data  in  INSTR_W  instruction returned.
- out_valid  out  1  queue head is valid.
- out_instr  out  INSTR_W  head instruction.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_ready  in  1  decode consumes the head (equivalent to not stalled).

Behaviour:
- Reset (asynchronous, active-high):
  - fetch_pc = RESET_PC, state = FETCH, queue count = 0.
  - out_valid = 0, imem_req = 0.
  - A reset that arrives while a request is outstanding abandons that request. The memory is reset by the same signal.
- At most one request outstanding. States:
  - FETCH: no request outstanding.
  - WAIT: request outstanding, response to be kept.
  - KILL: request outstanding, response to be discarded.
- imem_req is asserted only when all of the following hold:
  - state is FETCH, or state is WAIT with imem_rsp_valid this cycle;
  - redirect_valid = 0;
  - free slots remain, i.e. count − pop + (rsp accepted this cycle) < DEPTH.
- imem_req is combinational from state and inputs. imem_addr = fetch_pc whenever imem_req = 1.
- A grant occurs when imem_req and imem_gnt are both high. On a grant:
  - fetch_pc += PC_INC, modulo 2^ADDR_W (wraps 0xFFFE→0x0000 at the defaults);
  - state becomes WAIT.
- Response in WAIT: push {imem_rsp_data, pc_of_request} into the queue. The PC of the outstanding request is held in a register. Next state:
  - WAIT if a new grant occurs in the same cycle (back-to-back, 1 instr/cycle with a 1-cycle memory);
  - FETCH otherwise.
- Response in KILL: data dropped, no push, state becomes FETCH.
- Queue output:
  - out_valid = (count != 0); out_instr and out_pc come from the head.
  - A pop occurs when out_valid and out_ready are both high.
  - A push and a pop in the same cycle leave count unchanged.
  - The queue never overflows, because the issue rule reserves a slot before issuing.
- Redirect cycle (redirect_valid = 1):
  - queue flushed (count = 0, pointers reset), fetch_pc = redirect_pc, no issue, any pop ignored;
  - from WAIT or KILL: if imem_rsp_valid is high this cycle, the response is dropped and the next state is FETCH; otherwise the next state is KILL;
  - from FETCH: stays FETCH.
  - The first redirected request goes out the next cycle at the earliest.
- out_valid is 0 in the cycle after a redirect. No stale instruction is ever presented after a redirect.
- Stall (out_ready = 0): the queue fills to DEPTH, then imem_req stays low. The outstanding request still completes into the reserved slot.

Decomposition:
- Package fetch_pkg holds:
  - the state encoding (FETCH, WAIT, KILL);
  - default constants RESET_PC and PC_INC;
  - a packed entry type {pc, instr}.
- Sub-module fetch_queue: a circular FIFO parametrised by DEPTH and entry width, with push, pop, flush, count, head and full/empty outputs. Flush has priority over push and pop.
- The top level holds the FSM, fetch_pc, the outstanding-PC register and the issue logic.

Test Plan:
- Reset, then a memory with fixed 1-cycle latency, grant always high, out_ready = 1 → requests at 0x0000, 0x0002, 0x0004 on consecutive cycles; out_pc follows 0x0000, 0x0002, … one per cycle after fill.
- out_ready held 0, DEPTH = 4 → exactly 4 grants, count = 4, imem_req stays 0. Raising out_ready → one pop per cycle and issue resumes; no instruction is lost or duplicated.
- 3-cycle memory latency; redirect_valid with redirect_pc = 0x0100 one cycle after the grant of 0x0006 → the 0x0006 response is dropped (KILL), the next request is 0x0100, and the first out_pc after the redirect is 0x0100.
- Redirect to 0x0200 coinciding with imem_rsp_valid → response dropped, state FETCH, the request for 0x0200 is issued the next cycle, and the queue is empty in the redirect+1 cycle.
- fetch_pc = 0xFFFE, sequential fetch → the next request address is 0x0000; out_pc values are 0xFFFE then 0x0000.
- rst asserted asynchronously mid-cycle while in WAIT with 2 queued entries → out_valid and imem_req fall immediately; after release the first request is to RESET_PC.
